// File: rtl/mem_access_if.sv
// Request and memory-port bundle for mem_access_unit.
// slave is the unit's view; master is the requester/memory side.
interface mem_access_if;
  logic        start;
  logic        is_write;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  start, is_write, size, sext,
    input  addr, wdata, mem_rdata,
    output busy, done, err, rdata,
    output mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output start, is_write, size, sext,
    output addr, wdata, mem_rdata,
    input  busy, done, err, rdata,
    input  mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: lane select, sign extension, and
// read-modify-write for sub-word stores over a word memory.
module mem_access_unit #(
  parameter int READ_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  lo_q;
  logic        mis_q;
  logic [15:0] wd_q;
  logic [31:0] rdata_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;

  logic        word_req;
  logic        mis;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ld;
  logic [31:0] mg;

  // reserved size 11 behaves as a word access
  assign word_req = (bus.size == 2'b00)
                  | (bus.size == 2'b11);
  assign mis = ((bus.size == 2'b01) & bus.addr[0])
             | (word_req & (bus.addr[1:0] != 2'b00));

  always_comb begin
    b  = bus.mem_rdata[{lo_q, 3'b000} +: 8];
    h  = bus.mem_rdata[{lo_q[1], 4'b0000} +: 16];
    ld = bus.mem_rdata;
    mg = bus.mem_rdata;
    unique case (1'b1)
      size_q == 2'b10: begin
        ld = {{24{sext_q & b[7]}}, b};
        mg[{lo_q, 3'b000} +: 8] = wd_q[7:0];
      end
      size_q == 2'b01: begin
        ld = {{16{sext_q & h[15]}}, h};
        mg[{lo_q[1], 4'b0000} +: 16] = wd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      lo_q     <= 2'b00;
      mis_q    <= 1'b0;
      wd_q     <= 16'h0;
      rdata_q  <= 32'h0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          wr_q    <= bus.is_write;
          size_q  <= bus.size;
          sext_q  <= bus.sext;
          lo_q    <= bus.addr[1:0];
          mis_q   <= mis;
          wd_q    <= bus.wdata[15:0];
          maddr_q <= {bus.addr[31:2], 2'b00};
          cnt     <= 3'd0;
          if (mis) begin
            state <= FINISH;
          end else if (bus.is_write & word_req) begin
            mwdata_q <= bus.wdata;
            state    <= WRITE;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == 3'(READ_LAT - 1)) state <= CAPTURE;
          else cnt <= cnt + 3'd1;
        end
        CAPTURE: begin
          if (wr_q) begin
            mwdata_q <= mg;
            state    <= WRITE;
          end else begin
            rdata_q <= ld;
            state   <= FINISH;
          end
        end
        WRITE:   state <= FINISH;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FINISH);
  assign bus.err       = (state == FINISH) & mis_q;
  assign bus.mem_wr    = (state == WRITE);
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

endmodule
